// File: rtl/lcd_pkg.sv
// Shared definitions for the HD44780 4-bit bus controllers: state encoding,
// default bus timing and the busy-flag position in the status byte.
package lcd_pkg;

   typedef enum logic [3:0] {
      ST_IDLE     = 4'd0,
      ST_SETUP_HI = 4'd1,
      ST_EN_HI    = 4'd2,
      ST_HOLD_HI  = 4'd3,
      ST_GAP      = 4'd4,
      ST_SETUP_LO = 4'd5,
      ST_EN_LO    = 4'd6,
      ST_HOLD_LO  = 4'd7
   } lcd_state_e;

   localparam int LCD_SETUP_CYC = 1;
   localparam int LCD_EN_CYC    = 4;
   localparam int LCD_HOLD_CYC  = 1;
   localparam int LCD_GAP_CYC   = 24;
   localparam int LCD_MAX_POLLS = 255;
   localparam int BUSY_BIT      = 7;

   function automatic logic lcd_busy_flag(input logic [7:0] status_byte);
      return status_byte[BUSY_BIT];
   endfunction

endpackage

// File: rtl/lcd_phase_cnt.sv
// 8-bit loadable down-counter timing each bus phase; zero marks the last
// cycle of the phase currently loaded.
module lcd_phase_cnt
   import lcd_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       load,
   input  logic [7:0] value,
   output logic       zero
);

   logic [7:0] cnt_r;

   // Reload on state entry, otherwise count down and park at zero
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_r <= 8'd0;
      end else if (load) begin
         cnt_r <= value;
      end else if (cnt_r != 8'd0) begin
         cnt_r <= cnt_r - 8'd1;
      end else begin
         cnt_r <= cnt_r;
      end
   end

   assign zero = (cnt_r == 8'd0);

endmodule

// File: rtl/lcd_rd_ctrl.sv
// HD44780 4-bit read controller: two enable-strobed nibble reads per byte,
// with optional repeated status reads until the busy flag clears.
module lcd_rd_ctrl
   import lcd_pkg::*;
#(
   parameter int SETUP_CYC = LCD_SETUP_CYC,
   parameter int EN_CYC    = LCD_EN_CYC,
   parameter int HOLD_CYC  = LCD_HOLD_CYC,
   parameter int GAP_CYC   = LCD_GAP_CYC,
   parameter int MAX_POLLS = LCD_MAX_POLLS
)(
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic       rs,
   input  logic       poll,
   input  logic [3:0] lcd_data_in,
   output logic       rs_out,
   output logic       rw_out,
   output logic       enable,
   output logic [7:0] dataout,
   output logic       valid,
   output logic       busy,
   output logic       timeout
);

   localparam logic [7:0] SETUP_LEN_C = 8'(SETUP_CYC - 1);
   localparam logic [7:0] EN_LEN_C    = 8'(EN_CYC - 1);
   localparam logic [7:0] HOLD_LEN_C  = 8'(HOLD_CYC - 1);
   localparam logic [7:0] GAP_LEN_C   = 8'(GAP_CYC - 1);
   localparam logic [7:0] MAX_POLLS_C = 8'(MAX_POLLS);

   lcd_state_e state_r;
   lcd_state_e state_nxt_s;
   logic       load_s;
   logic [7:0] load_val_s;
   logic       zero_s;
   logic       poll_r;
   logic [7:0] poll_cnt_r;
   logic [3:0] hi_r;
   logic [3:0] lo_r;
   logic [7:0] byte_s;
   logic       poll_again_s;

   assign byte_s       = {hi_r, lo_r};
   assign poll_again_s = poll_r && lcd_busy_flag(byte_s) && (poll_cnt_r < MAX_POLLS_C);

   lcd_phase_cnt u_phase_cnt (
      .clk   (clk),
      .rst   (rst),
      .load  (load_s),
      .value (load_val_s),
      .zero  (zero_s)
   );

   // Next-state decode; every transition reloads the phase counter
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         ST_IDLE:     if (start)  state_nxt_s = ST_SETUP_HI; else state_nxt_s = ST_IDLE;
         ST_SETUP_HI: if (zero_s) state_nxt_s = ST_EN_HI;    else state_nxt_s = ST_SETUP_HI;
         ST_EN_HI:    if (zero_s) state_nxt_s = ST_HOLD_HI;  else state_nxt_s = ST_EN_HI;
         ST_HOLD_HI:  if (zero_s) state_nxt_s = ST_GAP;      else state_nxt_s = ST_HOLD_HI;
         ST_GAP:      if (zero_s) state_nxt_s = ST_SETUP_LO; else state_nxt_s = ST_GAP;
         ST_SETUP_LO: if (zero_s) state_nxt_s = ST_EN_LO;    else state_nxt_s = ST_SETUP_LO;
         ST_EN_LO:    if (zero_s) state_nxt_s = ST_HOLD_LO;  else state_nxt_s = ST_EN_LO;
         ST_HOLD_LO: begin
            if (!zero_s) begin
               state_nxt_s = ST_HOLD_LO;
            end else if (poll_again_s) begin
               state_nxt_s = ST_SETUP_HI;
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         default:     state_nxt_s = ST_IDLE;
      endcase
   end

   // Phase length of the state being entered
   always_comb begin
      load_s     = (state_nxt_s != state_r);
      load_val_s = 8'd0;
      case (state_nxt_s)
         ST_SETUP_HI, ST_SETUP_LO: load_val_s = SETUP_LEN_C;
         ST_EN_HI,    ST_EN_LO:    load_val_s = EN_LEN_C;
         ST_HOLD_HI,  ST_HOLD_LO:  load_val_s = HOLD_LEN_C;
         ST_GAP:                   load_val_s = GAP_LEN_C;
         default:                  load_val_s = 8'd0;
      endcase
   end

   // State, nibble capture and registered bus/handshake outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r    <= ST_IDLE;
         rs_out     <= 1'b0;
         rw_out     <= 1'b0;
         enable     <= 1'b0;
         dataout    <= 8'h00;
         valid      <= 1'b0;
         busy       <= 1'b0;
         timeout    <= 1'b0;
         poll_r     <= 1'b0;
         poll_cnt_r <= 8'd0;
         hi_r       <= 4'h0;
         lo_r       <= 4'h0;
      end else begin
         state_r <= state_nxt_s;
         valid   <= 1'b0;
         timeout <= 1'b0;
         enable  <= (state_nxt_s == ST_EN_HI) || (state_nxt_s == ST_EN_LO);
         case (state_r)
            ST_IDLE: begin
               if (start) begin
                  rs_out     <= rs;
                  rw_out     <= 1'b1;
                  busy       <= 1'b1;
                  poll_r     <= poll;
                  poll_cnt_r <= 8'd1;
               end
            end
            ST_EN_HI: begin
               if (zero_s) hi_r <= lcd_data_in;
            end
            ST_EN_LO: begin
               if (zero_s) lo_r <= lcd_data_in;
            end
            ST_HOLD_LO: begin
               if (zero_s) begin
                  if (poll_again_s) begin
                     poll_cnt_r <= poll_cnt_r + 8'd1;
                  end else begin
                     dataout <= byte_s;
                     valid   <= 1'b1;
                     timeout <= poll_r && lcd_busy_flag(byte_s);
                     rw_out  <= 1'b0;
                     busy    <= 1'b0;
                  end
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_lcd_rd_ctrl.sv
// Directed bench for lcd_rd_ctrl: an LCD model serves scripted bytes nibble
// by nibble on each enable pulse; timing and data are checked per scenario.
module tb_lcd_rd_ctrl;

   logic       clk;
   logic       rst;
   logic       start;
   logic       rs;
   logic       poll;
   logic [3:0] lcd_data_in;
   logic       rs_out;
   logic       rw_out;
   logic       enable;
   logic [7:0] dataout;
   logic       valid;
   logic       busy;
   logic       timeout;

   int n_checks;
   int n_errors;

   logic [7:0] script [0:7];
   logic       model_clr;
   int         pulse_cnt;
   logic       en_d;

   lcd_rd_ctrl #(.MAX_POLLS(3)) dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .rs          (rs),
      .poll        (poll),
      .lcd_data_in (lcd_data_in),
      .rs_out      (rs_out),
      .rw_out      (rw_out),
      .enable      (enable),
      .dataout     (dataout),
      .valid       (valid),
      .busy        (busy),
      .timeout     (timeout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // LCD model: each rising enable presents the next nibble (high first)
   always @(negedge clk) begin
      logic [7:0] b;
      if (model_clr) begin
         pulse_cnt   = 0;
         en_d        = 1'b0;
         lcd_data_in = 4'h0;
      end else begin
         if (enable && !en_d) begin
            b = script[(pulse_cnt >> 1) & 7];
            lcd_data_in = pulse_cnt[0] ? b[3:0] : b[7:4];
            pulse_cnt = pulse_cnt + 1;
         end
         en_d = enable;
      end
   end

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks = n_checks + 1;
      if (obs !== exp) begin
         n_errors = n_errors + 1;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      model_clr = 1'b1;
      for (int i = 0; i < 8; i++) script[i] = 8'h00;
      @(posedge clk);
      @(posedge clk);
      model_clr = 1'b0;
      @(negedge clk);
   endtask

   // Issue a start at the next edge and follow the transaction to valid
   task automatic run_rd(input logic rs_i, input logic poll_i, input int ign1, input int ign2,
                         output int lat, output int rw_cnt, output int busy_cnt,
                         output int en_cnt, output int first_en);
      start = 1'b1;
      rs    = rs_i;
      poll  = poll_i;
      @(posedge clk);
      @(negedge clk);
      start    = 1'b0;
      lat      = -1;
      first_en = -1;
      rw_cnt   = int'(rw_out);
      busy_cnt = int'(busy);
      en_cnt   = int'(enable);
      for (int k = 1; k <= 400 && lat < 0; k++) begin
         start = (k == ign1) || (k == ign2);
         @(posedge clk);
         @(negedge clk);
         rw_cnt   = rw_cnt + int'(rw_out);
         busy_cnt = busy_cnt + int'(busy);
         en_cnt   = en_cnt + int'(enable);
         if (enable && first_en < 0) first_en = k;
         if (valid) lat = k;
      end
      start = 1'b0;
   endtask

   initial begin
      int lat, rw_cnt, busy_cnt, en_cnt, first_en, vcnt;
      n_checks  = 0;
      n_errors  = 0;
      rst       = 1'b1;
      start     = 1'b0;
      rs        = 1'b0;
      poll      = 1'b0;
      model_clr = 1'b1;
      for (int i = 0; i < 8; i++) script[i] = 8'h00;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_eq("rst_rs_out",  32'(rs_out),  32'h0);
      check_eq("rst_rw_out",  32'(rw_out),  32'h0);
      check_eq("rst_enable",  32'(enable),  32'h0);
      check_eq("rst_dataout", 32'(dataout), 32'h00);
      check_eq("rst_valid",   32'(valid),   32'h0);
      check_eq("rst_busy",    32'(busy),    32'h0);
      check_eq("rst_timeout", 32'(timeout), 32'h0);
      rst = 1'b0;
      model_reset();

      // Plain data read
      script[0] = 8'hA5;
      run_rd(1'b1, 1'b0, -1, -1, lat, rw_cnt, busy_cnt, en_cnt, first_en);
      check_eq("t1_latency",  32'(lat),      32'd36);
      check_eq("t1_dataout",  32'(dataout),  32'hA5);
      check_eq("t1_rs_out",   32'(rs_out),   32'h1);
      check_eq("t1_rw_cycles",32'(rw_cnt),   32'd36);
      check_eq("t1_en_cycles",32'(en_cnt),   32'd8);
      check_eq("t1_first_en", 32'(first_en), 32'd1);
      check_eq("t1_pulses",   32'(pulse_cnt),32'd2);
      check_eq("t1_timeout",  32'(timeout),  32'h0);
      check_eq("t1_busy_end", 32'(busy),     32'h0);
      @(posedge clk);
      @(negedge clk);
      check_eq("t1_valid_1cyc", 32'(valid),  32'h0);

      // Status poll: busy, busy, then ready
      model_reset();
      script[0] = 8'h8C;
      script[1] = 8'h8C;
      script[2] = 8'h0C;
      run_rd(1'b0, 1'b1, -1, -1, lat, rw_cnt, busy_cnt, en_cnt, first_en);
      check_eq("t2_latency",  32'(lat),      32'd108);
      check_eq("t2_dataout",  32'(dataout),  32'h0C);
      check_eq("t2_timeout",  32'(timeout),  32'h0);
      check_eq("t2_pulses",   32'(pulse_cnt),32'd6);
      check_eq("t2_rw_cycles",32'(rw_cnt),   32'd108);
      check_eq("t2_rs_out",   32'(rs_out),   32'h0);

      // Poll gives up after MAX_POLLS reads
      model_reset();
      for (int i = 0; i < 8; i++) script[i] = 8'hFF;
      run_rd(1'b0, 1'b1, -1, -1, lat, rw_cnt, busy_cnt, en_cnt, first_en);
      check_eq("t3_latency",  32'(lat),      32'd108);
      check_eq("t3_dataout",  32'(dataout),  32'hFF);
      check_eq("t3_timeout",  32'(timeout),  32'h1);
      check_eq("t3_pulses",   32'(pulse_cnt),32'd6);
      @(posedge clk);
      @(negedge clk);
      check_eq("t3_timeout_1cyc", 32'(timeout), 32'h0);

      // Starts while busy are ignored
      model_reset();
      script[0] = 8'h5A;
      run_rd(1'b1, 1'b0, 10, 20, lat, rw_cnt, busy_cnt, en_cnt, first_en);
      check_eq("t4_latency",  32'(lat),      32'd36);
      check_eq("t4_busy_cyc", 32'(busy_cnt), 32'd36);
      check_eq("t4_dataout",  32'(dataout),  32'h5A);
      repeat (3) begin
         @(posedge clk);
         @(negedge clk);
      end
      check_eq("t4_idle_busy",  32'(busy),      32'h0);
      check_eq("t4_pulses",     32'(pulse_cnt), 32'd2);

      // Back-to-back: start issued in the valid cycle
      model_reset();
      script[0] = 8'h12;
      script[1] = 8'h34;
      run_rd(1'b1, 1'b0, -1, -1, lat, rw_cnt, busy_cnt, en_cnt, first_en);
      check_eq("t6_valid_a",  32'(valid),    32'h1);
      check_eq("t6_data_a",   32'(dataout),  32'h12);
      run_rd(1'b0, 1'b0, -1, -1, lat, rw_cnt, busy_cnt, en_cnt, first_en);
      check_eq("t6_latency_b",32'(lat),      32'd36);
      check_eq("t6_first_en", 32'(first_en), 32'd1);
      check_eq("t6_data_b",   32'(dataout),  32'h34);
      check_eq("t6_busy_b",   32'(busy_cnt), 32'd36);

      // Reset in the inter-nibble gap
      model_reset();
      script[0] = 8'h77;
      start = 1'b1;
      rs    = 1'b1;
      poll  = 1'b0;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      for (int k = 1; k <= 14; k++) begin
         @(posedge clk);
         @(negedge clk);
      end
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      check_eq("t5_enable",  32'(enable),  32'h0);
      check_eq("t5_rw_out",  32'(rw_out),  32'h0);
      check_eq("t5_busy",    32'(busy),    32'h0);
      check_eq("t5_dataout", 32'(dataout), 32'h00);
      check_eq("t5_rs_out",  32'(rs_out),  32'h0);
      vcnt = 0;
      for (int k = 0; k < 50; k++) begin
         @(posedge clk);
         @(negedge clk);
         vcnt = vcnt + int'(valid) + int'(busy);
      end
      check_eq("t5_no_valid", 32'(vcnt), 32'd0);

      // Start coinciding with reset is dropped
      start = 1'b1;
      rst   = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      rst   = 1'b0;
      @(posedge clk);
      @(negedge clk);
      check_eq("t5_start_lost", 32'(busy), 32'h0);

      // Fresh transaction after reset
      model_reset();
      script[0] = 8'h3C;
      run_rd(1'b1, 1'b0, -1, -1, lat, rw_cnt, busy_cnt, en_cnt, first_en);
      check_eq("t5_latency", 32'(lat),     32'd36);
      check_eq("t5_dataout", 32'(dataout), 32'h3C);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
